// File: rtl/arbitro_pkg.sv
// Shared types and sizes for the four-source round-robin arbiter.
package arbitro_pkg;

    localparam int NUM_FONTES  = 4;
    localparam int LARGURA_SEL = 2;

    // Arbiter FSM: idle, or one source holding the mux.
    typedef enum logic {
        OCIOSO    = 1'b0,
        CONCEDIDO = 1'b1
    } estado_t;

endpackage

// File: rtl/prioridade_rr4.sv
// Combinational rotating-priority search: scans ponteiro, ponteiro+1, ...
// modulo 4 and reports the first requesting index.
module prioridade_rr4
    import arbitro_pkg::*;
(
    input  logic [NUM_FONTES-1:0]  requisicao,
    input  logic [LARGURA_SEL-1:0] ponteiro,
    output logic                   encontrado,
    output logic [LARGURA_SEL-1:0] indice
);

    logic [LARGURA_SEL-1:0] candidato;

    // First set request bit at or after the pointer, wrapping around.
    always_comb begin
        encontrado = 1'b0;
        indice     = ponteiro;
        candidato  = ponteiro;
        for (int k = 0; k < NUM_FONTES; k++) begin
            candidato = ponteiro + LARGURA_SEL'(k);
            if (!encontrado && requisicao[candidato]) begin
                encontrado = 1'b1;
                indice     = candidato;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr4.sv
// Round-robin arbiter for four sources driving the select and data-valid
// of the downstream 4:1 mux. Grants are held until the owner releases them.
// Define ARBITRO_TIMEOUT_EN to add a watchdog that revokes a grant after
// TIMEOUT_CICLOS cycles and pulses estouro.
//
// Handshake: valido=1 means concessao/seletor name the current owner. The
// owner ends its turn by pulsing liberacao (only sampled while valido=1) or
// by dropping its requisicao bit; the next grant appears one edge later.
module arbitro_rr4
    import arbitro_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_FONTES-1:0]  requisicao,
    input  logic                   liberacao,
    output logic [NUM_FONTES-1:0]  concessao,
    output logic [LARGURA_SEL-1:0] seletor,
    output logic                   valido,
    output logic                   estouro
);

    estado_t                estado, estado_prox;
    logic [LARGURA_SEL-1:0] ponteiro, ponteiro_prox;
    logic [NUM_FONTES-1:0]  concessao_prox;
    logic [LARGURA_SEL-1:0] seletor_prox;
    logic                   valido_prox;
    logic                   liberacao_normal;
    logic                   expirou;
    logic                   evento;
    logic                   novo_grant;
    logic [NUM_FONTES-1:0]  req_busca;
    logic [LARGURA_SEL-1:0] ptr_busca;
    logic                   encontrado;
    logic [LARGURA_SEL-1:0] indice;

`ifdef ARBITRO_TIMEOUT_EN
    localparam int LARGURA_CONT = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [LARGURA_CONT-1:0] LIMITE = LARGURA_CONT'(TIMEOUT_CICLOS - 1);

    logic [LARGURA_CONT-1:0] contador;
    logic                    estouro_prox;

    assign expirou = valido && (contador == LIMITE);
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CICLOS > 0);
    assign expirou        = 1'b0;
`endif

    // Search inputs: while granted, start after the owner and hide its bit.
    always_comb begin
        liberacao_normal = liberacao || !requisicao[seletor];
        evento           = liberacao_normal || expirou;
        ptr_busca        = ponteiro;
        req_busca        = requisicao;
        if (estado == CONCEDIDO) begin
            ptr_busca = seletor + 1'b1;
            req_busca = requisicao & ~(NUM_FONTES'(1) << seletor);
        end
    end

    prioridade_rr4 u_prioridade (
        .requisicao (req_busca),
        .ponteiro   (ptr_busca),
        .encontrado (encontrado),
        .indice     (indice)
    );

    // Next-state and next-output decisions for the grant FSM.
    always_comb begin
        estado_prox    = estado;
        ponteiro_prox  = ponteiro;
        concessao_prox = concessao;
        seletor_prox   = seletor;
        valido_prox    = valido;
        novo_grant     = 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
        estouro_prox   = 1'b0;
`endif
        case (estado)
            OCIOSO: begin
                if (encontrado) begin
                    estado_prox    = CONCEDIDO;
                    seletor_prox   = indice;
                    concessao_prox = NUM_FONTES'(1) << indice;
                    valido_prox    = 1'b1;
                    novo_grant     = 1'b1;
                end
            end
            CONCEDIDO: begin
                if (evento) begin
                    ponteiro_prox = seletor + 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
                    estouro_prox  = expirou && !liberacao_normal;
`endif
                    if (encontrado) begin
                        seletor_prox   = indice;
                        concessao_prox = NUM_FONTES'(1) << indice;
                        novo_grant     = 1'b1;
                    end else begin
                        // Selector keeps its last value to avoid a mux glitch.
                        estado_prox    = OCIOSO;
                        concessao_prox = '0;
                        valido_prox    = 1'b0;
                    end
                end
            end
            default: begin
                estado_prox    = OCIOSO;
                concessao_prox = '0;
                valido_prox    = 1'b0;
            end
        endcase
    end

    // State, pointer and registered mux controls.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado    <= OCIOSO;
            ponteiro  <= '0;
            concessao <= '0;
            seletor   <= '0;
            valido    <= 1'b0;
        end else begin
            estado    <= estado_prox;
            ponteiro  <= ponteiro_prox;
            concessao <= concessao_prox;
            seletor   <= seletor_prox;
            valido    <= valido_prox;
        end
    end

`ifdef ARBITRO_TIMEOUT_EN
    // Watchdog: cycles the current grant has been held, plus the revoke pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            contador <= '0;
            estouro  <= 1'b0;
        end else begin
            estouro <= estouro_prox;
            if (novo_grant) begin
                contador <= '0;
            end else if (valido) begin
                contador <= contador + 1'b1;
            end
        end
    end
`else
    assign estouro = 1'b0;
`endif

endmodule

// File: doc/arbitro_rr4.md
# arbitro_rr4

Round-robin arbiter for four requesters. It produces the registered 2-bit selector and the data-valid qualifier for the 4:1 `mux` that sits directly downstream. It grants one source at a time, holds the grant until that source releases it, and rotates priority so no requester starves. Optionally, a watchdog forces release of a grant that is held too long.

## Interface
Parameters:
- `TIMEOUT_CICLOS`, default 16: maximum number of cycles a grant may stay active when `ARBITRO_TIMEOUT_EN` is defined. Legal range 2..256.

Ports:
- `clock`  in  1: single clock; everything updates on the rising edge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `requisicao`  in  4: per-source request, level-sensitive; bit i corresponds to mux `entrada(i+1)`.
- `liberacao`  in  1: the current owner releases its grant; sampled only while `valido`=1.
- `concessao`  out  4: one-hot grant, registered.
- `seletor`  out  2: index of the granted source, registered; drives the mux `seletor`.
- `valido`  out  1: a grant is active and the mux output is meaningful.
- `estouro`  out  1: one-cycle pulse when a grant was forcibly revoked by the watchdog.

## Operation
- States:
  - `OCIOSO`: no grant active.
  - `CONCEDIDO`: a grant is active.
- Rotating pointer `ponteiro` (2 bits) marks the highest-priority index.
- Search rule: scan `ponteiro`, `ponteiro`+1, … modulo 4; the first index with `requisicao` set wins.
- `OCIOSO`:
  - If any `requisicao` bit is set: move to `CONCEDIDO`; load `seletor` = winner, `concessao` = one-hot(winner), `valido` = 1.
  - Otherwise stay in `OCIOSO`.
- `CONCEDIDO`:
  - A release event is any of:
    - `liberacao` = 1;
    - `requisicao[seletor]` = 0;
    - watchdog expiry (only with `ARBITRO_TIMEOUT_EN`).
  - On a release event:
    - `ponteiro` becomes `seletor`+1 (mod 4).
    - Re-arbitration uses the updated pointer and `requisicao` with the releasing bit masked for that one cycle.
    - If a winner is found: direct handoff with no idle cycle, stay in `CONCEDIDO`.
    - If no winner: go to `OCIOSO`.
  - Without a release event: all outputs hold.
- On entering `OCIOSO`:
  - `concessao` = 0 and `valido` = 0.
  - `seletor` keeps its last value; no glitch on the mux select.
- `liberacao` while `valido` = 0 is ignored.
- Reset values: state = `OCIOSO`, `ponteiro` = 0, `concessao` = 0, `seletor` = 0, `valido` = 0, `estouro` = 0, watchdog counter = 0.

## Timing
- Latency from request to grant: 1 cycle. A request sampled at edge N produces a grant visible after edge N.
- Latency from release to next grant or idle: 1 cycle. Handoff is back-to-back.
- Simultaneous release and new requests: the new requests take part in the same re-arbitration.
- Reset mid-grant: all outputs return to reset values after the next edge with `reset_n` = 0. Any pending grant is dropped and `ponteiro` returns to 0.

## Configuration
- Macro: `ARBITRO_TIMEOUT_EN`.
- With the macro defined:
  - A counter with width ceil(log2(`TIMEOUT_CICLOS`)) clears on every new grant and increments each cycle while `valido` = 1.
  - When the counter equals `TIMEOUT_CICLOS`-1, that cycle counts as a release event. The grant therefore lasts exactly `TIMEOUT_CICLOS` cycles.
  - `estouro` is registered high for the single following cycle.
  - A normal release in the same cycle as expiry does not assert `estouro`.
- Without the macro:
  - No counter exists and `estouro` is tied to 0.
  - A grant is held indefinitely until it is released by `liberacao` or by the owner dropping its request.

## Structure
- Package `arbitro_pkg` holds:
  - the state enum (`OCIOSO`, `CONCEDIDO`);
  - `NUM_FONTES` = 4;
  - `LARGURA_SEL` = 2.
- Sub-module `prioridade_rr4` (combinational):
  - Inputs: the 4-bit request vector and the pointer.
  - Outputs: `encontrado` and a 2-bit `indice`.
  - It is instantiated once.
- The top level holds the FSM, the pointer register, the output registers and the optional watchdog.

## Test plan
- Reset behaviour:
  - Stimulus: `reset_n` = 0 with `requisicao` = 1111 for 3 cycles.
  - Required: `concessao` = 0000, `valido` = 0, `seletor` = 00.
  - Stimulus: deassert `reset_n`.
  - Required: after the first edge, `concessao` = 0001, `seletor` = 00.
- Rotation:
  - Stimulus: `requisicao` = 1111 held; `liberacao` pulsed for 1 cycle once per grant.
  - Required: `seletor` sequence 0,1,2,3,0; `valido` never drops.
- Wrap-around skip:
  - Stimulus: with `ponteiro` = 2 (after the owner at index 1 releases), apply `requisicao` = 0011.
  - Required: grant goes to index 0; `concessao` = 0001.
- Owner drops request:
  - Stimulus: index 1 granted, then `requisicao` drops 0010 → 0000 with `liberacao` = 0.
  - Required: next cycle `valido` = 0, `concessao` = 0000, `seletor` holds 01.
- Watchdog:
  - Stimulus: `TIMEOUT_CICLOS` = 4, `requisicao` = 0101 held, no `liberacao`.
  - Required with the macro: index 0 granted for exactly 4 cycles, then index 2 granted with `estouro` = 1 for one cycle.
  - Required without the macro: index 0 is still granted after 100 cycles and `estouro` stays 0.
- Reset mid-grant:
  - Stimulus: pulse `reset_n` = 0 for 1 cycle while index 3 is granted.
  - Required: outputs return to reset values. The next grant with `requisicao` = 1000 is index 3, found by a scan starting at `ponteiro` = 0.
